// File: rtl/isp_pkg.sv
// isp_pkg
// Shared constants for the ISP colour-conversion blocks.
// Holds the default component width, the BT.601 full-range coefficients
// (scaled by 256), the rounding offsets and the per-pixel sideband struct.
// No ports: this file is imported with "import isp_pkg::*;".
package isp_pkg;

   localparam int PIX_WID_DEF = 8;

   // Coefficients carry COEF_FRAC fractional bits; ROUND_OFS is one half LSB
   // of the final result so the closing right shift rounds to nearest.
   localparam int COEF_FRAC = 8;
   localparam int ROUND_OFS = 1 << (COEF_FRAC - 1);

   localparam int Y_KR  = 77;
   localparam int Y_KG  = 150;
   localparam int Y_KB  = 29;
   localparam int CB_KR = -43;
   localparam int CB_KG = -85;
   localparam int CB_KB = 128;
   localparam int CR_KR = 128;
   localparam int CR_KG = -107;
   localparam int CR_KB = -21;

   // Sideband flags that travel alongside each pixel.
   typedef struct packed {
      logic start;
      logic lineLast;
      logic last;
   } sideband_t;

   // Chroma is centred at mid-scale, so its offset is mid-scale (pre-shift)
   // plus the usual rounding half.
   function automatic int chromaOfs(input int pixWid);
      return (1 << (pixWid - 1 + COEF_FRAC)) + ROUND_OFS;
   endfunction

endpackage

// File: rtl/csc_mac.sv
// csc_mac
// One colour-space output channel: a 3-term signed multiply-accumulate with
// rounding offset, arithmetic shift and saturation to 0..2^PIX_WID-1.
// Three register stages (products, sum, saturated result), all advancing
// together when en_i is high.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en_i           pipeline advance enable
//   a_i, b_i, c_i  unsigned input components (R, G, B)
//   res_o          registered, saturated result
module csc_mac
   import isp_pkg::*;
#(
   parameter int PIX_WID = PIX_WID_DEF,
   parameter int K0      = 0,
   parameter int K1      = 0,
   parameter int K2      = 0,
   parameter int OFS     = ROUND_OFS
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [PIX_WID-1:0] a_i,
   input  logic [PIX_WID-1:0] b_i,
   input  logic [PIX_WID-1:0] c_i,
   output logic [PIX_WID-1:0] res_o
);

   // Narrow pixels still need room for 9-bit coefficients plus growth, so
   // the accumulator never drops below PIX_WID+11 bits.
   localparam int ACC_W = (2 * PIX_WID + 3 > PIX_WID + 11) ? 2 * PIX_WID + 3 : PIX_WID + 11;

   localparam logic signed [ACC_W-1:0] K0S  = ACC_W'(K0);
   localparam logic signed [ACC_W-1:0] K1S  = ACC_W'(K1);
   localparam logic signed [ACC_W-1:0] K2S  = ACC_W'(K2);
   localparam logic signed [ACC_W-1:0] OFSS = ACC_W'(OFS);
   localparam logic signed [ACC_W-1:0] MAXS = ACC_W'((1 << PIX_WID) - 1);

   logic signed [ACC_W-1:0] aExt, bExt, cExt;
   logic signed [ACC_W-1:0] prod0_q, prod1_q, prod2_q;
   logic signed [ACC_W-1:0] sum_d, sum_q;
   logic signed [ACC_W-1:0] scaled;
   logic [PIX_WID-1:0]      res_d, res_q;

   assign aExt = $signed({{(ACC_W - PIX_WID){1'b0}}, a_i});
   assign bExt = $signed({{(ACC_W - PIX_WID){1'b0}}, b_i});
   assign cExt = $signed({{(ACC_W - PIX_WID){1'b0}}, c_i});

   // Stage 2 adds the three products and the offset; stage 3 shifts the
   // registered sum and clamps it into the unsigned output range.
   always_comb begin
      sum_d  = prod0_q + prod1_q + prod2_q + OFSS;
      scaled = sum_q >>> COEF_FRAC;
      if (scaled[ACC_W-1]) begin
         res_d = '0;
      end else if (scaled > MAXS) begin
         res_d = '1;
      end else begin
         res_d = scaled[PIX_WID-1:0];
      end
   end

   // All three stages move in lockstep; holding en_i low freezes the whole
   // channel so a stalled pixel keeps its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod0_q <= '0;
         prod1_q <= '0;
         prod2_q <= '0;
         sum_q   <= '0;
         res_q   <= '0;
      end else if (en_i) begin
         prod0_q <= K0S * aExt;
         prod1_q <= K1S * bExt;
         prod2_q <= K2S * cExt;
         sum_q   <= sum_d;
         res_q   <= res_d;
      end
   end

   assign res_o = res_q;

endmodule

// File: rtl/rgb2ycbcr.sv
// rgb2ycbcr
// Streaming RGB to YCbCr (BT.601 full range) converter with valid/ready
// handshakes on both sides. Three-stage pipeline built from three csc_mac
// channels; valids and sideband flags ride alongside in this module.
// Defining RGB2YCBCR_422_EN adds a fourth stage that emits 4:2:2 output
// {Y, C, 0} with C alternating Cb (even pixel) / Cr (odd pixel), each the
// rounded average of the pair.
// Ports:
//   clk, rst_n                            clock, asynchronous active-low reset
//   src_valid/src_ready/src_data          input pixel {R,G,B}, R in MSBs
//   src_start/src_line_last/src_last      input sideband flags
//   dst_valid/dst_ready/dst_data          output pixel {Y,Cb,Cr}, Y in MSBs
//   dst_start/dst_line_last/dst_last      output sideband flags
module rgb2ycbcr
   import isp_pkg::*;
#(
   parameter int PIX_WID = PIX_WID_DEF
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [3*PIX_WID-1:0] src_data,
   input  logic                 src_start,
   input  logic                 src_line_last,
   input  logic                 src_last,
   output logic                 dst_valid,
   input  logic                 dst_ready,
   output logic [3*PIX_WID-1:0] dst_data,
   output logic                 dst_start,
   output logic                 dst_line_last,
   output logic                 dst_last
);

   logic               advance;
   logic [PIX_WID-1:0] rIn, gIn, bIn;
   logic [PIX_WID-1:0] yS3, cbS3, crS3;
   sideband_t          srcSb;
   logic [2:0]         vld_q;
   sideband_t          sb1_q, sb2_q, sb3_q;

   // A single global enable: every stage, bubbles included, moves only when
   // the output is not blocked, so nothing is lost, duplicated or compacted.
   assign advance   = !(dst_valid && !dst_ready);
   assign src_ready = advance;

   assign {rIn, gIn, bIn} = src_data;
   assign srcSb = {src_start, src_line_last, src_last};

   // Valid bits and sideband flags shadow the csc_mac data registers stage
   // for stage. Flags of a bubble are forced low so stale flags never leak.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         sb1_q <= '0;
         sb2_q <= '0;
         sb3_q <= '0;
      end else if (advance) begin
         vld_q <= {vld_q[1:0], src_valid};
         sb1_q <= src_valid ? srcSb : '0;
         sb2_q <= sb1_q;
         sb3_q <= sb2_q;
      end
   end

   csc_mac #(.PIX_WID(PIX_WID), .K0(Y_KR), .K1(Y_KG), .K2(Y_KB), .OFS(ROUND_OFS)) uMacY (
      .clk(clk), .rst_n(rst_n), .en_i(advance),
      .a_i(rIn), .b_i(gIn), .c_i(bIn), .res_o(yS3)
   );

   csc_mac #(.PIX_WID(PIX_WID), .K0(CB_KR), .K1(CB_KG), .K2(CB_KB), .OFS(chromaOfs(PIX_WID))) uMacCb (
      .clk(clk), .rst_n(rst_n), .en_i(advance),
      .a_i(rIn), .b_i(gIn), .c_i(bIn), .res_o(cbS3)
   );

   csc_mac #(.PIX_WID(PIX_WID), .K0(CR_KR), .K1(CR_KG), .K2(CR_KB), .OFS(chromaOfs(PIX_WID))) uMacCr (
      .clk(clk), .rst_n(rst_n), .en_i(advance),
      .a_i(rIn), .b_i(gIn), .c_i(bIn), .res_o(crS3)
   );

`ifdef RGB2YCBCR_422_EN
   logic               phase_q;
   logic               isOdd;
   logic [PIX_WID-1:0] holdY_q, holdCb_q, holdCr_q;
   sideband_t          holdSb_q;
   logic               pendValid_q;
   logic [PIX_WID-1:0] pendY_q, pendC_q;
   sideband_t          pendSb_q;
   logic               outValid_q;
   logic [3*PIX_WID-1:0] outData_q;
   sideband_t          outSb_q;
   logic [PIX_WID:0]   cbSum, crSum;

   // A frame start always opens a new pair, regardless of leftover phase.
   assign isOdd = sb3_q.start ? 1'b0 : phase_q;
   assign cbSum = {1'b0, holdCb_q} + {1'b0, cbS3} + (PIX_WID + 1)'(1);
   assign crSum = {1'b0, holdCr_q} + {1'b0, crS3} + (PIX_WID + 1)'(1);

   // Even pixels wait in the hold register. When the odd partner arrives
   // the even pixel leaves with the averaged Cb and the odd pixel is parked
   // with the averaged Cr, going out on the next advancing cycle. An odd
   // pixel is always followed by an even one, so the park slot is free
   // whenever it is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q     <= 1'b0;
         holdY_q     <= '0;
         holdCb_q    <= '0;
         holdCr_q    <= '0;
         holdSb_q    <= '0;
         pendValid_q <= 1'b0;
         pendY_q     <= '0;
         pendC_q     <= '0;
         pendSb_q    <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outSb_q     <= '0;
      end else if (advance) begin
         outValid_q  <= 1'b0;
         pendValid_q <= 1'b0;
         if (vld_q[2] && isOdd) begin
            outValid_q  <= 1'b1;
            outData_q   <= {holdY_q, cbSum[PIX_WID:1], {PIX_WID{1'b0}}};
            outSb_q     <= holdSb_q;
            pendValid_q <= 1'b1;
            pendY_q     <= yS3;
            pendC_q     <= crSum[PIX_WID:1];
            pendSb_q    <= sb3_q;
         end else if (pendValid_q) begin
            outValid_q <= 1'b1;
            outData_q  <= {pendY_q, pendC_q, {PIX_WID{1'b0}}};
            outSb_q    <= pendSb_q;
         end
         if (vld_q[2] && !isOdd) begin
            holdY_q  <= yS3;
            holdCb_q <= cbS3;
            holdCr_q <= crS3;
            holdSb_q <= sb3_q;
         end
         if (vld_q[2]) begin
            phase_q <= sb3_q.lineLast ? 1'b0 : !isOdd;
         end
      end
   end

   assign dst_valid     = outValid_q;
   assign dst_data      = outData_q;
   assign dst_start     = outSb_q.start;
   assign dst_line_last = outSb_q.lineLast;
   assign dst_last      = outSb_q.last;
`else
   assign dst_valid     = vld_q[2];
   assign dst_data      = {yS3, cbS3, crS3};
   assign dst_start     = sb3_q.start;
   assign dst_line_last = sb3_q.lineLast;
   assign dst_last      = sb3_q.last;
`endif

endmodule
